// File: rtl/operand_fetch_pkg.sv
// Shared enums for the operand-fetch path: operand source encoding from the
// decoder and the fetch FSM state, exposed so benches can probe the state.
package operand_fetch_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    SRC_IMMEDIATE = 2'd0,
    SRC_REG       = 2'd1,
    SRC_MEM_ADDR  = 2'd2,
    SRC_INDIRECT  = 2'd3
  } data_src_t;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_RD_PTR  = 2'd1,
    FS_RD_DATA = 2'd2,
    FS_DONE    = 2'd3
  } fetch_state_t;

  // State entered from idle when a request of the given source is accepted.
  function automatic fetch_state_t first_state(input data_src_t src);
    case (src)
      SRC_MEM_ADDR: first_state = FS_RD_DATA;
      SRC_INDIRECT: first_state = FS_RD_PTR;
      default:      first_state = FS_DONE;
    endcase
  endfunction

  function automatic logic needs_mem(input data_src_t src);
    needs_mem = (src == SRC_MEM_ADDR) || (src == SRC_INDIRECT);
  endfunction

endpackage

// File: rtl/operand_fetch.sv
// Operand-fetch unit: performs zero, one or two memory reads depending on the
// operand source and hands the fetched byte to execute with valid/ack.
//
// state      | meaning
// FS_IDLE    | ready for a decoder request
// FS_RD_PTR  | reading the pointer for an indirect operand
// FS_RD_DATA | reading the operand byte
// FS_DONE    | operand presented, waiting for operand_ack
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  data_src_t        source,
  input  logic [WIDTH-1:0] id_operand,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_rvalid,
  output logic [WIDTH-1:0] mem_data,
  output logic             operand_valid,
  input  logic             operand_ack
);

  fetch_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      case (state)
        FS_IDLE: begin
          if (start) begin
            state <= first_state(source);
            if (needs_mem(source)) mem_addr <= id_operand;
          end
        end
        // The pointer becomes the next address; mem_rd stays high so the
        // data read goes out on the following cycle without a gap.
        FS_RD_PTR: begin
          if (mem_rvalid) begin
            mem_addr <= mem_rdata;
            state    <= FS_RD_DATA;
          end
        end
        FS_RD_DATA: begin
          if (mem_rvalid) begin
            mem_data <= mem_rdata;
            state    <= FS_DONE;
          end
        end
        FS_DONE: begin
          if (operand_ack) state <= FS_IDLE;
        end
        default: state <= FS_IDLE;
      endcase
    end
  end

  assign ready         = (state == FS_IDLE);
  assign mem_rd        = (state == FS_RD_PTR) || (state == FS_RD_DATA);
  assign operand_valid = (state == FS_DONE);

  a_no_rd_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FS_IDLE || state == FS_DONE) |-> !mem_rd);

  a_hold_until_ack: assert property (@(posedge clk) disable iff (!rst_n)
    (operand_valid && !operand_ack) |=> (operand_valid && $stable(mem_data)));

endmodule
